program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Serial program loader for the UL8 CPU: receives a framed program image over UART 8N1 and writes it into the CPU's 32x8 program/data RAM through a write port.
- Holds the CPU in its RESET state while a load is in progress or after a failed load, so the CPU never executes a partial image.
- Sits between the board UART RX pin and the CPU's RAM write port. Replaces the compile-time program image as the normal way to get a program onto the board.

Parameters:
- CLKS_PER_BIT, 234: clock cycles per UART bit (27 MHz / 115200).
- MEM_DEPTH, 32: RAM words; the maximum legal program length.
- ADDR_W, 5: RAM address width.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_BYTES, 16: inter-byte gap, in byte times (10*CLKS_PER_BIT cycles each), that aborts a frame in progress.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  UART receive line, idle high, asynchronous to clk
- mem_we  out  1  RAM write strobe, one-cycle pulse
- mem_addr  out  ADDR_W  RAM write address
- mem_wdata  out  8  RAM write data
- cpu_hold  out  1  high = CPU forced to and held in RESET
- busy  out  1  high while a frame is being received
- load_done  out  1  level; last frame loaded and checksum passed
- load_err  out  1  level; last frame aborted or failed

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, both FSMs idle, all counters 0. While cpu_hold is 0 the CPU runs its existing RAM contents.

rx input and UART receiver:
- rx passes through a 2-flop synchronizer; that 2-cycle delay is part of all timing below.
- RX_IDLE: a synchronized falling edge goes to RX_START.
- RX_START: wait CLKS_PER_BIT/2 cycles, then sample. If the line is still low, go to RX_DATA; if it is high (glitch), go back to RX_IDLE.
- RX_DATA: sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample (mid-bit).
- RX_STOP: sample at mid-bit.
  - Line high: byte_valid pulses for 1 cycle, in the cycle after the sample.
  - Line low: frame_err pulses for 1 cycle instead. The receiver returns to RX_IDLE only after the line is seen high.

Frame protocol: SYNC_BYTE, LEN, LEN data bytes, SUM. SUM is the 8-bit wrap-around sum of the data bytes.

Frame FSM:
- F_WAIT_SYNC:
  - byte == SYNC_BYTE: go to F_LEN; set busy=1 and cpu_hold=1; clear load_done and load_err; reset the address counter and the running sum.
  - Any other byte, or a framing error: ignored.
- F_LEN:
  - 1 <= LEN <= MEM_DEPTH: store LEN, go to F_DATA.
  - LEN == 0 or LEN > MEM_DEPTH: go to F_ERR.
- F_DATA: for each byte, write it to RAM and add it to the running sum (modulo 256). After the LEN-th byte, go to F_SUM.
- F_SUM:
  - Byte equals the running sum: go to F_DONE.
  - Otherwise: go to F_ERR.
- F_DONE (one cycle): load_done=1, cpu_hold=0, busy=0, then back to F_WAIT_SYNC.
- F_ERR (one cycle): load_err=1, busy=0, cpu_hold stays 1, then back to F_WAIT_SYNC.
- In F_LEN, F_DATA or F_SUM, a framing error or a timeout (no byte_valid for TIMEOUT_BYTES*10*CLKS_PER_BIT cycles) goes to F_ERR.
- load_done and load_err are mutually exclusive. Both hold until the next accepted SYNC_BYTE or reset.
- cpu_hold is released only by a successful load or by reset.

RAM write:
- mem_we is registered and asserted in the cycle after the data byte's byte_valid.
- mem_addr = index of the byte in the frame (0..LEN-1); mem_wdata = the byte.
- No write ever occurs for SYNC, LEN or SUM bytes.
- RAM words at or above LEN are left unchanged.

Boundary cases:
- A SYNC_BYTE value arriving inside F_LEN, F_DATA or F_SUM is treated as an ordinary byte; there is no resync mid-frame.
- Reset in the middle of a frame: the frame is abandoned and cpu_hold drops to 0, even if RAM is partially written.
- An address counter overflow past MEM_DEPTH-1 is impossible, because LEN is validated before any write.

Decomposition:
- Shared package ul8_pkg holds:
  - the opcode constants (LDA, STV, ADD, NAN, JMP, JMN, NOT, HLT);
  - MEM_DEPTH, ADDR_W and SYNC_BYTE;
  - the frame-FSM state enum.
- Sub-module uart_rx: synchronizer, bit-timing FSM, byte_valid/frame_err/data outputs. The frame FSM, checksum, timeout counter and write port stay in program_loader.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_BYTES=2):
- Send A5,03,20,41,E0,41 -> 3 mem_we pulses at addr 0,1,2 with data 20,41,E0; load_done=1, load_err=0, cpu_hold 1->0 after the last byte, busy back to 0.
- Send A5,02,10,20,31 (correct sum 30) -> 2 writes occur; load_err=1, load_done=0, cpu_hold stays 1.
- Send 00,FF then A5,01,07,07 -> leading bytes ignored with no writes; one write of 07 at addr 0; load_done=1.
- Send A5,00 and, separately, A5,21 -> load_err=1 with zero mem_we pulses in both cases.
- Send A5,04,01 then leave rx idle -> load_err=1 exactly 160 cycles after the byte_valid of 01; only one write occurred; cpu_hold=1.
- Send a stop bit forced low inside the data phase -> load_err=1. Pulse rx low for 3 cycles while idle -> no byte_valid. Assert reset mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ul8_pkg.sv
// Shared UL8 definitions: instruction opcodes, memory geometry and the
// program-loader frame states.
package ul8_pkg;

  localparam logic [2:0] LDA = 3'd0;
  localparam logic [2:0] STV = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] NAN = 3'd3;
  localparam logic [2:0] JMP = 3'd4;
  localparam logic [2:0] JMN = 3'd5;
  localparam logic [2:0] NOT = 3'd6;
  localparam logic [2:0] HLT = 3'd7;

  localparam int         MEM_DEPTH = 32;
  localparam int         ADDR_W    = 5;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    F_WAIT_SYNC,
    F_LEN,
    F_DATA,
    F_SUM,
    F_DONE,
    F_ERR
  } frame_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] data
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t        state;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Synchronizer flops come out of reset at the idle level so reset
  // release never looks like a start-bit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              data       <= shift;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: accepts a SYNC/LEN/data/SUM frame over UART and
// writes it into UL8 RAM, holding the CPU in reset until a load succeeds.
module program_loader
  import ul8_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 234,
  parameter int TIMEOUT_BYTES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic       byte_valid, frame_err;
  logic [7:0] rx_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .data       (rx_data)
  );

  frame_state_t     state;
  logic [ADDR_W:0]  len_reg;
  logic [ADDR_W:0]  addr_reg;
  logic [7:0]       sum_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic             in_frame;
  logic             timeout;
  logic             len_ok;

  // tmo_reg counts cycles elapsed since the most recent byte_valid, so the
  // abort lands exactly TIMEOUT_CYCLES after it.
  assign in_frame = (state == F_LEN) || (state == F_DATA) || (state == F_SUM);
  assign timeout  = in_frame && !byte_valid && (tmo_reg == TMO_LAST);
  assign len_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MEM_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= F_WAIT_SYNC;
      len_reg   <= '0;
      addr_reg  <= '0;
      sum_reg   <= '0;
      tmo_reg   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (byte_valid)    tmo_reg <= TMO_W'(1);
      else if (in_frame) tmo_reg <= tmo_reg + 1'b1;

      // Status outputs change on the transition edge, so load_done/load_err
      // are already high during the one-cycle F_DONE/F_ERR states.
      case (state)
        F_WAIT_SYNC: begin
          if (byte_valid && rx_data == SYNC_BYTE) begin
            state     <= F_LEN;
            busy      <= 1'b1;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            addr_reg  <= '0;
            sum_reg   <= '0;
          end
        end
        F_LEN: begin
          if (byte_valid && len_ok) begin
            len_reg <= rx_data[ADDR_W:0];
            state   <= F_DATA;
          end else if (byte_valid || frame_err || timeout) begin
            state    <= F_ERR;
            load_err <= 1'b1;
            busy     <= 1'b0;
          end
        end
        F_DATA: begin
          if (byte_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_reg[ADDR_W-1:0];
            mem_wdata <= rx_data;
            sum_reg   <= sum_reg + rx_data;
            addr_reg  <= addr_reg + 1'b1;
            if (addr_reg == len_reg - 1'b1) state <= F_SUM;
          end else if (frame_err || timeout) begin
            state    <= F_ERR;
            load_err <= 1'b1;
            busy     <= 1'b0;
          end
        end
        F_SUM: begin
          if (byte_valid && rx_data == sum_reg) begin
            state     <= F_DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
          end else if (byte_valid || frame_err || timeout) begin
            state    <= F_ERR;
            load_err <= 1'b1;
            busy     <= 1'b0;
          end
        end
        F_DONE:  state <= F_WAIT_SYNC;
        F_ERR:   state <= F_WAIT_SYNC;
        default: state <= F_WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of whole frames plus hand-built sequences
// for timeout, bad stop bit, start-bit glitch and mid-frame reset.
module tb_program_loader;

  localparam int CPB = 8;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold, busy, load_done, load_err;

  program_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BYTES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [0:7][7:0] bytes;
    int              n;
    int              first;
    int              nw;
    logic            done;
    logic            err;
    logic            hold;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vec[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   we_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.addr));
        chk("write_data", 32'(mem_wdata), 32'(e.data));
        $display("write addr=%0d data=%h", mem_addr, mem_wdata);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input logic done, input logic err, input logic hold);
    $display("%s: done=%0b err=%0b hold=%0b busy=%0b", tag, load_done, load_err, cpu_hold, busy);
    chk({tag, "_load_done"}, 32'(load_done), 32'(done));
    chk({tag, "_load_err"}, 32'(load_err), 32'(err));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit got;
    int rise_cyc;

    vec[0] = '{{8'hA5, 8'h03, 8'h20, 8'h41, 8'hE0, 8'h41, 8'h00, 8'h00}, 6, 2, 3, 1'b1, 1'b0, 1'b0};
    vec[1] = '{{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00, 8'h00}, 5, 2, 2, 1'b0, 1'b1, 1'b1};
    vec[2] = '{{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h07, 8'h07, 8'h00, 8'h00}, 6, 4, 1, 1'b1, 1'b0, 1'b0};
    vec[3] = '{{8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA6, 8'h00, 8'h00, 8'h00}, 5, 2, 2, 1'b1, 1'b0, 1'b0};
    vec[4] = '{{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 2, 0, 1'b0, 1'b1, 1'b1};
    vec[5] = '{{8'hA5, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 2, 0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vec[v].nw; i++)
        exp_q.push_back('{addr: 5'(i), data: vec[v].bytes[vec[v].first + i]});
      for (int i = 0; i < vec[v].n; i++) send_byte(vec[v].bytes[i], 1'b1);
      repeat (20) @(negedge clk);
      check_end($sformatf("frame%0d", v), vec[v].done, vec[v].err, vec[v].hold);
    end

    // Start-bit glitch between two data bytes must not create a byte.
    exp_q.push_back('{addr: 5'd0, data: 8'h33});
    exp_q.push_back('{addr: 5'd1, data: 8'h44});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h33, 1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'h44, 1'b1);
    send_byte(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    check_end("glitch", 1'b1, 1'b0, 1'b0);

    // Inter-byte timeout after one data byte.
    exp_q.push_back('{addr: 5'd0, data: 8'h01});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("tmo_busy_mid", 32'(busy), 32'd1);
    chk("tmo_err_early", 32'(load_err), 32'd0);
    got = 1'b0;
    rise_cyc = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (load_err) begin
        got = 1'b1;
        rise_cyc = cyc;
      end
    end
    chk("tmo_seen", 32'(got), 32'd1);
    chk("tmo_latency", 32'(rise_cyc - we_cyc), 32'd159);
    repeat (5) @(negedge clk);
    check_end("timeout", 1'b0, 1'b1, 1'b1);

    // Stop bit held low inside the data phase.
    exp_q.push_back('{addr: 5'd0, data: 8'h11});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (20) @(negedge clk);
    check_end("stop_low", 1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    exp_q.push_back('{addr: 5'd0, data: 8'h01});
    exp_q.push_back('{addr: 5'd1, data: 8'h02});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("mid_mem_addr", 32'(mem_addr), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_load_done", 32'(load_done), 32'd0);
    chk("arst_load_err", 32'(load_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_end("after_reset", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
